// File: rtl/cdb_arbiter_if.sv
// Bundle of FU result inputs, flush and CDB broadcast outputs for cdb_arbiter.
// The master drives FU results and flush; the slave (the arbiter) drives ready and the CDB.
interface cdb_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 6
);
  logic                      flush;
  logic [2:0]                fu_valid;
  logic [2:0]                fu_ready;
  logic [3*DATA_WIDTH-1:0]   fu_data;
  logic [3*TAG_WIDTH-1:0]    fu_tag;
  logic [1:0]                cdb_valid;
  logic [2*DATA_WIDTH-1:0]   cdb_data;
  logic [2*TAG_WIDTH-1:0]    cdb_tag;

  modport master (
    output flush, fu_valid, fu_data, fu_tag,
    input  fu_ready, cdb_valid, cdb_data, cdb_tag
  );

  modport slave (
    input  flush, fu_valid, fu_data, fu_tag,
    output fu_ready, cdb_valid, cdb_data, cdb_tag
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Three-FU to two-lane common data bus arbiter with a 2-entry FIFO per FU
// and round-robin lane assignment starting at rr_q.
module cdb_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 6
) (
  input logic          clk,
  input logic          rst_n,
  cdb_arbiter_if.slave bus
);

  localparam int unsigned NFU   = 3;
  localparam int unsigned DEPTH = 2;

  logic [DATA_WIDTH-1:0] data_q [NFU][DEPTH];
  logic [TAG_WIDTH-1:0]  tag_q  [NFU][DEPTH];

  logic [1:0]     cnt_q [NFU];
  logic [1:0]     cnt_d [NFU];
  logic [NFU-1:0] wr_ptr_q, wr_ptr_d;
  logic [NFU-1:0] rd_ptr_q, rd_ptr_d;
  logic [1:0]     rr_q, rr_d;

  logic [NFU-1:0] ready;
  logic [NFU-1:0] push;
  logic [NFU-1:0] gnt;
  logic [1:0]     sel0, sel1;
  logic           v0, v1;
  logic [1:0]     last;
  logic [1:0]     nfound;
  logic [2:0]     sum;
  logic [1:0]     idx;

  // Ready comes from registered occupancy only, so a full FIFO cannot refill on its pop cycle.
  always_comb begin
    ready = '0;
    push  = '0;
    for (int unsigned i = 0; i < NFU; i++) begin
      ready[i] = (cnt_q[i] < 2'd2);
      push[i]  = bus.fu_valid[i] & ready[i] & ~bus.flush;
    end
  end

  always_comb begin
    gnt    = '0;
    sel0   = '0;
    sel1   = '0;
    v0     = 1'b0;
    v1     = 1'b0;
    last   = '0;
    nfound = '0;
    sum    = '0;
    idx    = '0;
    for (int unsigned j = 0; j < NFU; j++) begin
      sum = {1'b0, rr_q} + 3'(j);
      idx = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
      if ((cnt_q[idx] != 2'd0) && (nfound != 2'd2)) begin
        gnt[idx] = 1'b1;
        last     = idx;
        if (nfound == 2'd0) begin
          sel0 = idx;
          v0   = 1'b1;
        end else begin
          sel1 = idx;
          v1   = 1'b1;
        end
        nfound = nfound + 2'd1;
      end
    end
  end

  always_comb begin
    rr_d     = rr_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    for (int unsigned i = 0; i < NFU; i++) begin
      cnt_d[i] = cnt_q[i];
    end
    if (bus.flush) begin
      rr_d     = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      for (int unsigned i = 0; i < NFU; i++) begin
        cnt_d[i] = '0;
      end
    end else begin
      if (v0) begin
        rr_d = (last == 2'd2) ? 2'd0 : last + 2'd1;
      end
      wr_ptr_d = wr_ptr_q ^ push;
      rd_ptr_d = rd_ptr_q ^ gnt;
      for (int unsigned i = 0; i < NFU; i++) begin
        case ({push[i], gnt[i]})
          2'b10:   cnt_d[i] = cnt_q[i] + 2'd1;
          2'b01:   cnt_d[i] = cnt_q[i] - 2'd1;
          default: cnt_d[i] = cnt_q[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int unsigned i = 0; i < NFU; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      rr_q     <= rr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      for (int unsigned i = 0; i < NFU; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Payload storage carries no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NFU; i++) begin
      if (push[i]) begin
        data_q[i][wr_ptr_q[i]] <= bus.fu_data[i*DATA_WIDTH +: DATA_WIDTH];
        tag_q[i][wr_ptr_q[i]]  <= bus.fu_tag[i*TAG_WIDTH +: TAG_WIDTH];
      end
    end
  end

  always_comb begin
    bus.fu_ready  = ready;
    bus.cdb_valid = {v1, v0};
    bus.cdb_data  = '0;
    bus.cdb_tag   = '0;
    if (v0) begin
      bus.cdb_data[0 +: DATA_WIDTH] = data_q[sel0][rd_ptr_q[sel0]];
      bus.cdb_tag[0 +: TAG_WIDTH]   = tag_q[sel0][rd_ptr_q[sel0]];
    end
    if (v1) begin
      bus.cdb_data[DATA_WIDTH +: DATA_WIDTH] = data_q[sel1][rd_ptr_q[sel1]];
      bus.cdb_tag[TAG_WIDTH +: TAG_WIDTH]    = tag_q[sel1][rd_ptr_q[sel1]];
    end
  end

endmodule
